// File: rtl/chip8_memory.sv
// CHIP-8 4 KB main memory: font init sequencer, program loader, CPU responder.
module chip8_memory #(
    parameter int unsigned DEPTH        = 4096,
    parameter logic [11:0] FONT_BASE    = 12'h000,
    parameter logic [11:0] LOAD_BASE    = 12'h200,
    parameter bit          FONT_PROTECT = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [11:0] mem_addr,
    input  logic [7:0]  mem_wdata,
    output logic [7:0]  mem_rdata,
    input  logic        load_valid,
    input  logic [7:0]  load_data,
    input  logic        load_done,
    output logic        load_ready,
    output logic        ready,
    output logic [11:0] prog_len,
    output logic        load_full
);

    localparam int unsigned AW       = 12;
    localparam int unsigned DW       = 8;
    localparam int unsigned FONT_LEN = 80;
    localparam int unsigned FCW      = 7;
    localparam logic [AW-1:0] LAST_ADDR = 12'hFFF;

    // Standard hex font, digits 0..F, 5 rows each.
    localparam logic [0:FONT_LEN-1][DW-1:0] FONT = {
        8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0,  // 0
        8'h20, 8'h60, 8'h20, 8'h20, 8'h70,  // 1
        8'hF0, 8'h10, 8'hF0, 8'h80, 8'hF0,  // 2
        8'hF0, 8'h10, 8'hF0, 8'h10, 8'hF0,  // 3
        8'h90, 8'h90, 8'hF0, 8'h10, 8'h10,  // 4
        8'hF0, 8'h80, 8'hF0, 8'h10, 8'hF0,  // 5
        8'hF0, 8'h80, 8'hF0, 8'h90, 8'hF0,  // 6
        8'hF0, 8'h10, 8'h20, 8'h40, 8'h40,  // 7
        8'hF0, 8'h90, 8'hF0, 8'h90, 8'hF0,  // 8
        8'hF0, 8'h90, 8'hF0, 8'h10, 8'hF0,  // 9
        8'hF0, 8'h90, 8'hF0, 8'h90, 8'h90,  // A
        8'hE0, 8'h90, 8'hE0, 8'h90, 8'hE0,  // B
        8'hF0, 8'h80, 8'h80, 8'h80, 8'hF0,  // C
        8'hE0, 8'h90, 8'h90, 8'h90, 8'hE0,  // D
        8'hF0, 8'h80, 8'hF0, 8'h80, 8'hF0,  // E
        8'hF0, 8'h80, 8'hF0, 8'h80, 8'h80   // F
    };

    typedef enum logic [1:0] {
        INIT_FONT = 2'd0,
        LOAD      = 2'd1,
        RUN       = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [FCW-1:0]  font_cnt_q, font_cnt_d;
    logic [AW-1:0]   prog_len_q, prog_len_d;
    logic            load_full_q, load_full_d;
    logic            load_ready_q, load_ready_d;
    logic            ready_q, ready_d;

    logic [DW-1:0]   mem [DEPTH];

    logic            we_c;
    logic [AW-1:0]   waddr_c;
    logic [DW-1:0]   wdata_c;
    logic [AW-1:0]   load_addr_c;
    logic            in_font_c;

    // CPU address falls inside the protected font window (13-bit compare avoids wrap).
    assign in_font_c = ({1'b0, mem_addr} >= {1'b0, FONT_BASE}) &&
                       ({1'b0, mem_addr} <  ({1'b0, FONT_BASE} + 13'(FONT_LEN)));

    assign load_addr_c = LOAD_BASE + prog_len_q;

    // Next-state, single RAM write port mux and registered status outputs.
    always_comb begin
        state_d    = state_q;
        font_cnt_d = font_cnt_q;
        prog_len_d = prog_len_q;
        load_full_d = load_full_q;
        we_c       = 1'b0;
        waddr_c    = '0;
        wdata_c    = '0;

        case (state_q)
            INIT_FONT: begin
                we_c    = 1'b1;
                waddr_c = FONT_BASE + AW'(font_cnt_q);
                wdata_c = FONT[font_cnt_q];
                if (font_cnt_q == FCW'(FONT_LEN - 1)) begin
                    font_cnt_d = '0;
                    state_d    = LOAD;
                end else begin
                    font_cnt_d = font_cnt_q + FCW'(1);
                end
            end
            LOAD: begin
                if (load_valid && load_ready_q) begin
                    we_c       = 1'b1;
                    waddr_c    = load_addr_c;
                    wdata_c    = load_data;
                    prog_len_d = prog_len_q + AW'(1);
                    if (load_addr_c == LAST_ADDR) begin
                        load_full_d = 1'b1;
                        state_d     = RUN;
                    end
                end
                if (load_done) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (mem_write && !(FONT_PROTECT && in_font_c)) begin
                    we_c    = 1'b1;
                    waddr_c = mem_addr;
                    wdata_c = mem_wdata;
                end
            end
            default: begin
                state_d    = INIT_FONT;
                font_cnt_d = '0;
            end
        endcase

        load_ready_d = (state_d == LOAD);
        ready_d      = (state_d == RUN);
    end

    // State and status registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= INIT_FONT;
            font_cnt_q   <= '0;
            prog_len_q   <= '0;
            load_full_q  <= 1'b0;
            load_ready_q <= 1'b0;
            ready_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            font_cnt_q   <= font_cnt_d;
            prog_len_q   <= prog_len_d;
            load_full_q  <= load_full_d;
            load_ready_q <= load_ready_d;
            ready_q      <= ready_d;
        end
    end

    // RAM array, deliberately not reset.
    always_ff @(posedge clk) begin
        if (we_c) begin
            mem[waddr_c] <= wdata_c;
        end
    end

    // Zero-latency read, only while serving the CPU.
    assign mem_rdata  = (state_q == RUN && mem_read) ? mem[mem_addr] : '0;
    assign load_ready = load_ready_q;
    assign ready      = ready_q;
    assign prog_len   = prog_len_q;
    assign load_full  = load_full_q;

endmodule
